divider_iterative: RTL and testbench

//  Sequential unsigned divider; inverse of the array multiplier. Takes a 2*width-bit dividend
//  (multiplier product format) and a width-bit divisor. Returns width-bit quotient and remainder.

---
 rtl/divider_if.sv | 24 ++
 rtl/divider_iterative.sv | 132 +++++++++++++
 tb/tb_divider_iterative.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// divider_if: valid/ready request and response bundle for divider_iterative
//   in_valid/in_ready    request handshake carrying dividend (2*width) and divisor (width)
//   out_valid/out_ready  response handshake carrying quotient, remainder, div_zero, overflow
//   master drives requests and accepts responses; slave is the divider side
interface divider_if #(parameter int width = 64);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*width-1:0]   dividend;
    logic [width-1:0]     divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic [width-1:0]     quotient;
    logic [width-1:0]     remainder;
    logic                 div_zero;
    logic                 overflow;
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero, overflow
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero, overflow
    );
endinterface

// File: rtl/divider_iterative.sv
// divider_iterative: sequential restoring unsigned divider, 2*width / width -> width quotient and remainder
//   clk    posedge clock
//   rst_n  asynchronous active-low reset
//   bus    divider_if.slave: request (in_valid, in_ready, dividend, divisor),
//          response (out_valid, out_ready, quotient, remainder, div_zero, overflow)
//   DIVIDER_RADIX4_EN defined: two restoring steps per RUN cycle, otherwise one
module divider_iterative #(
    parameter int width = 64
) (
    input  logic      clk,
    input  logic      rst_n,
    divider_if.slave  bus
);
`ifdef DIVIDER_RADIX4_EN
    localparam int steps = 2;
`else
    localparam int steps = 1;
`endif
    localparam int cw = $clog2(width + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nxt;
    logic [width:0]   r, r_nxt, rs;
    logic [width-1:0] q, q_nxt, qs;
    logic [width-1:0] d, d_nxt;
    logic [cw-1:0]    cnt, cnt_nxt;
    logic [width-1:0] quot, quot_nxt, rem, rem_nxt;
    logic             dz, dz_nxt, ov, ov_nxt;

    // One restoring step: shift the next dividend bit into the partial remainder,
    // subtract if it fits and record the quotient bit in the freed LSB of q.
    function automatic logic [2*width:0] step(input logic [width:0] ri, input logic [width-1:0] qi,
                                              input logic [width-1:0] di);
        logic [width+1:0] sh;
        logic [width:0]   t;
        logic             ge;
        sh = {ri, qi[width-1]};
        t  = sh[width:0] - {1'b0, di};
        ge = sh >= {2'b00, di};
        return {ge ? t : sh[width:0], qi[width-2:0], ge};
    endfunction

`ifdef DIVIDER_RADIX4_EN
    logic [width:0]   r1;
    logic [width-1:0] q1;
    always_comb begin
        {r1, q1} = step(r, q, d);
        {rs, qs} = step(r1, q1, d);
    end
`else
    always_comb {rs, qs} = step(r, q, d);
`endif

    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        q_nxt     = q;
        d_nxt     = d;
        cnt_nxt   = cnt;
        quot_nxt  = quot;
        rem_nxt   = rem;
        dz_nxt    = dz;
        ov_nxt    = ov;
        case (state)
            IDLE: if (bus.in_valid) begin
                d_nxt = bus.divisor;
                if (bus.divisor == '0) begin
                    state_nxt = DONE;
                    dz_nxt    = 1'b1;
                    ov_nxt    = 1'b0;
                    quot_nxt  = '1;
                    rem_nxt   = bus.dividend[width-1:0];
                end else if (bus.dividend[2*width-1:width] >= bus.divisor) begin
                    state_nxt = DONE;
                    dz_nxt    = 1'b0;
                    ov_nxt    = 1'b1;
                    quot_nxt  = '1;
                    rem_nxt   = '0;
                end else begin
                    state_nxt = RUN;
                    r_nxt     = {1'b0, bus.dividend[2*width-1:width]};
                    q_nxt     = bus.dividend[width-1:0];
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                r_nxt   = rs;
                q_nxt   = qs;
                cnt_nxt = cnt + cw'(steps);
                if (cnt == cw'(width - steps)) begin
                    state_nxt = DONE;
                    quot_nxt  = qs;
                    rem_nxt   = rs[width-1:0];
                    dz_nxt    = 1'b0;
                    ov_nxt    = 1'b0;
                end
            end
            DONE: state_nxt = bus.out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            r     <= '0;
            q     <= '0;
            d     <= '0;
            cnt   <= '0;
            quot  <= '0;
            rem   <= '0;
            dz    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            state <= state_nxt;
            r     <= r_nxt;
            q     <= q_nxt;
            d     <= d_nxt;
            cnt   <= cnt_nxt;
            quot  <= quot_nxt;
            rem   <= rem_nxt;
            dz    <= dz_nxt;
            ov    <= ov_nxt;
        end
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.quotient  = quot;
    assign bus.remainder = rem;
    assign bus.div_zero  = dz;
    assign bus.overflow  = ov;
endmodule

// File: tb/tb_divider_iterative.sv
// tb_divider_iterative: directed checks of divider_iterative at width 8 and width 64
module tb_divider_iterative;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   lat;
`ifdef DIVIDER_RADIX4_EN
    localparam int lat8 = 5;
    localparam int lat64 = 33;
`else
    localparam int lat8 = 9;
    localparam int lat64 = 65;
`endif

    always #5 clk = ~clk;

    divider_if #(.width(8))  b8();
    divider_if #(.width(64)) b64();

    divider_iterative #(.width(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    divider_iterative #(.width(64)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request, hold it until accepted, then scramble the inputs so a
    // divider that re-reads them after the accept edge gets caught.
    task automatic start8(input logic [15:0] dd, input logic [7:0] dv, output int n);
        int w = 0;
        @(negedge clk);
        b8.in_valid = 1'b1; b8.dividend = dd; b8.divisor = dv;
        while (!b8.in_ready && w < 100) begin @(negedge clk); w++; end
        check("accept8", b8.in_ready, 1);
        @(posedge clk); #1;
        b8.in_valid = 1'b0; b8.dividend = 16'hFFFF; b8.divisor = 8'd3;
        n = 1;
        @(negedge clk);
        while (!b8.out_valid && n < 200) begin @(negedge clk); n++; end
    endtask

    task automatic release8();
        @(negedge clk); b8.out_ready = 1'b1;
        @(negedge clk); b8.out_ready = 1'b0;
        check("drop out_valid8", b8.out_valid, 0);
        check("rise in_ready8", b8.in_ready, 1);
    endtask

    task automatic div8(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz,
                        input logic eov, input int elat);
        int n;
        start8(dd, dv, n);
        check({tag, " latency"}, n, elat);
        check({tag, " q"}, b8.quotient, eq);
        check({tag, " r"}, b8.remainder, er);
        check({tag, " div_zero"}, b8.div_zero, edz);
        check({tag, " overflow"}, b8.overflow, eov);
        release8();
    endtask

    task automatic div64(input string tag, input logic [127:0] dd, input logic [63:0] dv,
                         input logic [63:0] eq, input logic [63:0] er, input int elat);
        int n = 1;
        int w = 0;
        @(negedge clk);
        b64.in_valid = 1'b1; b64.dividend = dd; b64.divisor = dv;
        while (!b64.in_ready && w < 100) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        b64.in_valid = 1'b0; b64.dividend = '1; b64.divisor = 64'd5;
        @(negedge clk);
        while (!b64.out_valid && n < 200) begin @(negedge clk); n++; end
        if (elat != 0) check({tag, " latency"}, n, elat);
        check({tag, " q"}, b64.quotient, eq);
        check({tag, " r"}, b64.remainder, er);
        check({tag, " flags"}, {b64.div_zero, b64.overflow}, 0);
        @(negedge clk); b64.out_ready = 1'b1;
        @(negedge clk); b64.out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0]  a, b, c, rr;
        logic [127:0] p;
        b8.in_valid = 1'b0;  b8.out_ready = 1'b0;  b8.dividend = '0;  b8.divisor = '0;
        b64.in_valid = 1'b0; b64.out_ready = 1'b0; b64.dividend = '0; b64.divisor = '0;
        repeat (3) @(negedge clk);
        check("reset out_valid", b8.out_valid, 0);
        check("reset q", b8.quotient, 0);
        check("reset r", b8.remainder, 0);
        check("reset flags", {b8.div_zero, b8.overflow}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle in_ready", b8.in_ready, 1);

        div8("1000/7", 16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0, lat8);
        div8("div0", 16'h1234, 8'd0, 8'hFF, 8'h34, 1'b1, 1'b0, 1);
        div8("ovf", 16'h0800, 8'd8, 8'hFF, 8'd0, 1'b0, 1'b1, 1);
        div8("07FF/8", 16'h07FF, 8'd8, 8'd255, 8'd7, 1'b0, 1'b0, lat8);
        div8("zero dividend", 16'd0, 8'd5, 8'd0, 8'd0, 1'b0, 1'b0, lat8);
        div8("divisor 1", 16'h00AB, 8'd1, 8'hAB, 8'd0, 1'b0, 1'b0, lat8);
        div8("max square", 16'hFE01, 8'hFF, 8'hFF, 8'd0, 1'b0, 1'b0, lat8);

        // Result held under back-pressure while a competing request is offered.
        start8(16'd1000, 8'd7, lat);
        b8.in_valid = 1'b1; b8.dividend = 16'd100; b8.divisor = 8'd9;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold out_valid", b8.out_valid, 1);
            check("hold q", b8.quotient, 142);
            check("hold r", b8.remainder, 6);
            check("hold in_ready", b8.in_ready, 0);
        end
        b8.in_valid = 1'b0;
        release8();
        div8("after hold", 16'd100, 8'd9, 8'd11, 8'd1, 1'b0, 1'b0, lat8);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        b8.in_valid = 1'b1; b8.dividend = 16'd1000; b8.divisor = 8'd7;
        @(posedge clk); #1 b8.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst out_valid", b8.out_valid, 0);
        check("rst q", b8.quotient, 0);
        check("rst r", b8.remainder, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no stale result", b8.out_valid, 0);
        check("post rst in_ready", b8.in_ready, 1);
        div8("post rst 100/9", 16'd100, 8'd9, 8'd11, 8'd1, 1'b0, 1'b0, lat8);

        div64("w64 max square", 128'hFFFFFFFFFFFFFFFE0000000000000001, '1, '1, '0, lat64);
        for (int i = 0; i < 200; i++) begin
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom} | 64'd1;
            rr = {$urandom, $urandom};
            c  = rr % b;
            p  = {64'd0, a} * {64'd0, b} + {64'd0, c};
            div64("w64 random", p, b, a, c, i == 0 ? lat64 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
